// File: rtl/ram_arbiter.sv
// Two-master arbiter for the shared single-port data RAM.
// Arbitrates A/B, drives one RAM access cycle, then returns read data with a done pulse.
module ram_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_cs,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_out,
    input  logic [DATA_W-1:0] ram_data_in
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_b;
    logic               r_owner_b;
    logic               r_we;
    logic [CNT_W-1:0]   r_starve;
    logic [CNT_W-1:0]   w_starve_nxt;
    logic               w_pick_b;
    logic               w_win_a;
    logic               w_win_b;
    logic               w_we_sel;
    logic [ADDR_W-1:0]  w_addr_sel;
    logic [DATA_W-1:0]  w_wdata_sel;

    // Next state, winner selection and starvation counter update
    always_comb begin
        w_state_nxt  = r_state;
        w_win_a      = 1'b0;
        w_win_b      = 1'b0;
        w_starve_nxt = r_starve;

        if (ARB_MODE == 0) begin
            w_pick_b = b_req && (!a_req || !r_last_b);
        end else begin
            w_pick_b = b_req && (!a_req || (r_starve == CNT_W'(STARVE_MAX)));
        end

        case (r_state)
            S_IDLE, S_RESP: begin
                if (a_req || b_req) begin
                    w_state_nxt = S_ACCESS;
                    if (w_pick_b) begin
                        w_win_b = 1'b1;
                    end else begin
                        w_win_a = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            default:  w_state_nxt = S_IDLE;
        endcase

        if (w_win_b) begin
            w_starve_nxt = '0;
        end else if (w_win_a && b_req && (r_starve < CNT_W'(STARVE_MAX))) begin
            w_starve_nxt = r_starve + CNT_W'(1);
        end

        w_we_sel    = w_win_b ? b_we    : a_we;
        w_addr_sel  = w_win_b ? b_addr  : a_addr;
        w_wdata_sel = w_win_b ? b_wdata : a_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch, RAM strobes and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_b     <= 1'b1;
            r_owner_b    <= 1'b0;
            r_we         <= 1'b0;
            r_starve     <= '0;
            a_gnt        <= 1'b0;
            b_gnt        <= 1'b0;
            a_done       <= 1'b0;
            b_done       <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
            ram_cs       <= 1'b0;
            ram_re       <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_data_out <= '0;
        end else begin
            a_gnt    <= w_win_a;
            b_gnt    <= w_win_b;
            a_done   <= (r_state == S_ACCESS) && !r_owner_b;
            b_done   <= (r_state == S_ACCESS) && r_owner_b;
            ram_cs   <= w_win_a || w_win_b;
            ram_re   <= (w_win_a || w_win_b) && !w_we_sel;
            ram_we   <= (w_win_a || w_win_b) && w_we_sel;
            r_starve <= w_starve_nxt;

            if (w_win_a || w_win_b) begin
                r_last_b  <= w_win_b;
                r_owner_b <= w_win_b;
                r_we      <= w_we_sel;
                ram_addr  <= w_addr_sel;
                if (w_we_sel) begin
                    ram_data_out <= w_wdata_sel;
                end
            end

            if ((r_state == S_ACCESS) && !r_we) begin
                if (r_owner_b) begin
                    b_rdata <= ram_data_in;
                end else begin
                    a_rdata <= ram_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: round-robin instance with a RAM model,
// plus a fixed-priority instance (STARVE_MAX=2) for the starvation guard.
module tb_ram_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_gnt, a_done, b_gnt, b_done;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              ram_cs, ram_re, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_out, ram_data_in;

    logic              m1_a_req, m1_b_req;
    logic              m1_a_gnt, m1_a_done, m1_b_gnt, m1_b_done;
    logic [DATA_W-1:0] m1_a_rdata, m1_b_rdata;
    logic              m1_ram_cs, m1_ram_re, m1_ram_we;
    logic [ADDR_W-1:0] m1_ram_addr;
    logic [DATA_W-1:0] m1_ram_data_out;
    logic [DATA_W-1:0] m1_ram_data_in;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_we;

    logic [DATA_W-1:0] mem [256];

    assign ram_data_in = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data_out;
    end

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARB_MODE(0), .STARVE_MAX(4)) u0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .ram_cs(ram_cs), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
    );

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ARB_MODE(1), .STARVE_MAX(2)) u1 (
        .clk(clk), .rst(rst),
        .a_req(m1_a_req), .a_we(m1_we), .a_addr(m1_addr), .a_wdata(m1_wdata),
        .a_gnt(m1_a_gnt), .a_done(m1_a_done), .a_rdata(m1_a_rdata),
        .b_req(m1_b_req), .b_we(m1_we), .b_addr(m1_addr), .b_wdata(m1_wdata),
        .b_gnt(m1_b_gnt), .b_done(m1_b_done), .b_rdata(m1_b_rdata),
        .ram_cs(m1_ram_cs), .ram_re(m1_ram_re), .ram_we(m1_ram_we), .ram_addr(m1_ram_addr),
        .ram_data_out(m1_ram_data_out), .ram_data_in(m1_ram_data_in)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
        tick;
        check("pre_gnt", 32'(a_gnt), 32'd1);
        a_req = 1'b0;
        tick;
        check("pre_done", 32'(a_done), 32'd1);
        tick;
    endtask

    initial begin
        logic [5:0]        exp_b_seq;
        logic [DATA_W-1:0] exp_rd;

        m1_a_req = 1'b0; m1_b_req = 1'b0; m1_we = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_ram_data_in = '0;

        // 1: reset with random inputs, then idle
        repeat (3) begin
            a_req = 1'($urandom); a_we = 1'($urandom);
            a_addr = ADDR_W'($urandom); a_wdata = DATA_W'($urandom);
            b_req = 1'($urandom); b_we = 1'($urandom);
            b_addr = ADDR_W'($urandom); b_wdata = DATA_W'($urandom);
            tick;
        end
        check("rst_gnt",   32'({a_gnt, b_gnt}), 32'd0);
        check("rst_done",  32'({a_done, b_done}), 32'd0);
        check("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        check("rst_strb",  32'({ram_cs, ram_re, ram_we}), 32'd0);
        check("rst_addr",  32'(ram_addr), 32'd0);
        check("rst_dout",  32'(ram_data_out), 32'd0);
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        rst = 1'b1;
        repeat (3) tick;
        check("idle_cs",  32'(ram_cs), 32'd0);
        check("idle_gnt", 32'({a_gnt, b_gnt}), 32'd0);

        // 2: A write 0xBEEF @0x12, then read back
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h12; a_wdata = 16'hBEEF;
        tick;
        check("wr_gnt",  32'({a_gnt, b_gnt}), 32'b10);
        check("wr_strb", 32'({ram_cs, ram_re, ram_we}), 32'b101);
        check("wr_addr", 32'(ram_addr), 32'h12);
        check("wr_dout", 32'(ram_data_out), 32'hBEEF);
        a_req = 1'b0;
        tick;
        check("wr_done", 32'({a_done, b_done}), 32'b10);
        check("wr_cs",   32'(ram_cs), 32'd0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h12;
        tick;
        check("rd_gnt",  32'(a_gnt), 32'd1);
        check("rd_strb", 32'({ram_cs, ram_re, ram_we}), 32'b110);
        a_req = 1'b0;
        tick;
        check("rd_done",  32'(a_done), 32'd1);
        check("rd_data",  32'(a_rdata), 32'hBEEF);
        check("rd_brd",   32'(b_rdata), 32'd0);
        tick;
        check("rd_idle",  32'({a_done, ram_cs}), 32'd0);

        // 3: round-robin with both requesting continuously
        rst = 1'b0;
        tick;
        rst = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
        a_addr = 8'h12; b_addr = 8'h12;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("rr_gnt", 32'({a_gnt, b_gnt}), (k % 2 == 0) ? 32'b10 : 32'b01);
            check("rr_done_in_gnt", 32'({a_done, b_done}), 32'd0);
            if (k == 3) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            tick;
            check("rr_done", 32'({a_done, b_done}), (k % 2 == 0) ? 32'b10 : 32'b01);
            check("rr_gnt_in_done", 32'({a_gnt, b_gnt}), 32'd0);
        end
        tick;
        check("rr_idle", 32'(ram_cs), 32'd0);

        // 4: fixed priority with starvation guard (STARVE_MAX=2)
        exp_b_seq = 6'b100100;
        m1_a_req = 1'b1; m1_b_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            check("fp_gnt", 32'({m1_a_gnt, m1_b_gnt}), exp_b_seq[k] ? 32'b01 : 32'b10);
            tick;
            check("fp_done", 32'({m1_a_done, m1_b_done}), exp_b_seq[k] ? 32'b01 : 32'b10);
        end
        m1_a_req = 1'b0; m1_b_req = 1'b0;
        tick;

        // 5: back-to-back A reads of preloaded 0x00..0x03
        for (int i = 0; i < 4; i++) write_a(ADDR_W'(i), DATA_W'(16'h1111 * (i + 1)));
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("b2b_gnt", 32'(a_gnt), 32'd1);
            if (i == 3) a_req = 1'b0;
            else        a_addr = ADDR_W'(i + 1);
            tick;
            exp_rd = DATA_W'(16'h1111 * (i + 1));
            check("b2b_done", 32'(a_done), 32'd1);
            check("b2b_data", 32'(a_rdata), 32'(exp_rd));
        end
        tick;

        // 6: reset during a B write access
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'h40; b_wdata = 16'h5A5A;
        tick;
        check("mr_gnt",  32'({a_gnt, b_gnt}), 32'b01);
        check("mr_we",   32'({ram_cs, ram_we}), 32'b11);
        #2;
        rst = 1'b0;
        #1;
        check("mr_async", 32'({ram_cs, ram_re, ram_we}), 32'd0);
        b_req = 1'b0; b_we = 1'b0;
        tick;
        check("mr_nodone", 32'({a_done, b_done}), 32'd0);
        rst = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_addr = 8'h12; b_addr = 8'h12;
        tick;
        check("mr_tie", 32'({a_gnt, b_gnt}), 32'b10);
        a_req = 1'b0; b_req = 1'b0;
        tick;
        check("mr_done", 32'({a_done, b_done}), 32'b10);
        check("mr_data", 32'(a_rdata), 32'hBEEF);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
